// File: rtl/vu_pkg.sv
// Shared types and constants for the stereo peak-level meter.
package vu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2,
    DECAY = 2'd3
  } vu_state_e;

  localparam int NUM_LEDS     = 8;
  localparam int LVL_W        = 4;
  localparam int THR_BASE_EXP = 7;

  // |x| with -32768 clamped to 32767 so the result always fits in 15 bits
  function automatic logic [14:0] abs_sat(input logic [15:0] x);
    logic [15:0] neg;
    neg = 16'd0 - x;
    if (x == 16'h8000) begin
      abs_sat = 15'h7FFF;
    end else if (x[15]) begin
      abs_sat = neg[14:0];
    end else begin
      abs_sat = x[14:0];
    end
  endfunction

endpackage

// File: rtl/vu_level_enc.sv
// Magnitude to 0..8 level: one step per power of two from 2^THR_BASE_EXP upward.
module vu_level_enc
  import vu_pkg::*;
(
  input  logic [14:0]      mag,
  output logic [LVL_W-1:0] lvl
);

  // Count how many of the eight thresholds the magnitude reaches
  always_comb begin
    lvl = '0;
    for (int k = 1; k <= NUM_LEDS; k++) begin
      if (mag >= (15'd1 << (THR_BASE_EXP + k - 1))) begin
        lvl = lvl + LVL_W'(1);
      end else begin
        lvl = lvl;
      end
    end
  end

endmodule

// File: rtl/vu_meter.sv
// Stereo peak-hold LED meter. Define VU_PEAK_DOT_EN for a single-dot display
// instead of the default thermometer bar.
module vu_meter
  import vu_pkg::*;
#(
  parameter int HOLD_SAMPLES  = 2048,
  parameter int DECAY_SAMPLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [15:0]         lft_out,
  input  logic [15:0]         rht_out,
  input  logic                amp_on,
  output logic [NUM_LEDS-1:0] LED,
  output logic [LVL_W-1:0]    peak_lvl
);

  localparam int CNT_MAX = (HOLD_SAMPLES > DECAY_SAMPLES) ? HOLD_SAMPLES : DECAY_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_SAMPLES);
  localparam logic [CNT_W-1:0] DEC_INIT  = CNT_W'(DECAY_SAMPLES);

  logic                valid_q;
  logic                evt_s;
  logic                evt1_q;
  logic [14:0]         mag_d, mag_q;
  logic [14:0]         abs_l_s, abs_r_s;
  logic [LVL_W-1:0]    lvl_s;
  vu_state_e           state_d, state_q;
  logic [LVL_W-1:0]    disp_d, disp_q;
  logic [CNT_W-1:0]    hold_cnt_d, hold_cnt_q;
  logic [CNT_W-1:0]    dec_cnt_d, dec_cnt_q;
  logic [NUM_LEDS-1:0] led_d, led_q;

  assign evt_s   = valid & ~valid_q;
  assign abs_l_s = abs_sat(lft_out);
  assign abs_r_s = abs_sat(rht_out);
  assign mag_d   = (abs_l_s > abs_r_s) ? abs_l_s : abs_r_s;

  vu_level_enc u_enc (
    .mag (mag_q),
    .lvl (lvl_s)
  );

  // Peak-hold FSM; amp_on low overrides everything, including a sample in flight
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    hold_cnt_d = hold_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    if (!amp_on) begin
      state_d    = IDLE;
      disp_d     = '0;
      hold_cnt_d = '0;
      dec_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = TRACK;
        TRACK, HOLD, DECAY: begin
          if (!evt1_q) begin
            state_d = state_q;
          end else if ((lvl_s >= disp_q) && (lvl_s != '0)) begin
            disp_d     = lvl_s;
            hold_cnt_d = HOLD_INIT;
            state_d    = HOLD;
          end else if (state_q == HOLD) begin
            if (hold_cnt_q > CNT_W'(1)) begin
              hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end else begin
              hold_cnt_d = '0;
              dec_cnt_d  = DEC_INIT;
              state_d    = DECAY;
            end
          end else if (state_q == DECAY) begin
            if (dec_cnt_q > CNT_W'(1)) begin
              dec_cnt_d = dec_cnt_q - CNT_W'(1);
            end else begin
              dec_cnt_d = DEC_INIT;
              if (disp_q > LVL_W'(1)) begin
                disp_d  = disp_q - LVL_W'(1);
                state_d = DECAY;
              end else begin
                disp_d  = '0;
                state_d = TRACK;
              end
            end
          end else begin
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // LED pattern follows the next displayed level so LED and peak_lvl change together
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef VU_PEAK_DOT_EN
      led_d[i] = (disp_d == LVL_W'(i + 1));
`else
      led_d[i] = (LVL_W'(i) < disp_d);
`endif
    end
  end

  // Edge detect, magnitude stage, FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      evt1_q     <= 1'b0;
      mag_q      <= '0;
      state_q    <= IDLE;
      disp_q     <= '0;
      hold_cnt_q <= '0;
      dec_cnt_q  <= '0;
      led_q      <= '0;
    end else begin
      valid_q    <= valid;
      evt1_q     <= evt_s;
      mag_q      <= mag_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      hold_cnt_q <= hold_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      led_q      <= led_d;
    end
  end

  assign LED      = led_q;
  assign peak_lvl = disp_q;

endmodule

// File: tb/tb_vu_meter.sv
// Self-checking bench for vu_meter: directed scenarios plus a randomized run
// against a peak/hold/decay reference model written from the level rules.
module tb_vu_meter;

  localparam int H = 2048;
  localparam int D = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        amp_on;
  logic [15:0] lft;
  logic [15:0] rht;
  logic [7:0]  led;
  logic [3:0]  peak;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: level of the last arming sample and samples since then
  int m_peak = 0;
  int m_n    = 0;

  always #10 clk = ~clk;

  vu_meter #(.HOLD_SAMPLES(H), .DECAY_SAMPLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .lft_out  (lft),
    .rht_out  (rht),
    .amp_on   (amp_on),
    .LED      (led),
    .peak_lvl (peak)
  );

  function automatic int ref_level(input logic [15:0] l, input logic [15:0] r);
    int a, b, m, lv;
    a = $signed(l);
    b = $signed(r);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    m = (a > b) ? a : b;
    lv = 0;
    for (int k = 1; k <= 8; k++) if (m >= (1 << (6 + k))) lv++;
    return lv;
  endfunction

  function automatic logic [7:0] exp_led(input int lv);
    logic [7:0] v;
    logic [7:0] one;
    one = 8'h01;
    v = 8'h00;
`ifdef VU_PEAK_DOT_EN
    if (lv > 0) v = one << (lv - 1);
`else
    for (int i = 0; i < 8; i++) if (i < lv) v[i] = 1'b1;
`endif
    return v;
  endfunction

  function automatic int m_disp();
    int dv;
    if (m_peak == 0) return 0;
    if (m_n < H) return m_peak;
    dv = m_peak - (m_n - H) / D;
    return (dv < 0) ? 0 : dv;
  endfunction

  task automatic model_sample(input logic [15:0] l, input logic [15:0] r);
    int lv, cur;
    lv  = ref_level(l, r);
    cur = m_disp();
    if (lv > 0 && lv >= cur) begin
      m_peak = lv;
      m_n    = 0;
    end else begin
      m_n++;
    end
  endtask

  // one sample event, two clocks; returns with its effect already visible
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    lft   = l;
    rht   = r;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    if (amp_on) model_sample(l, r);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    lft   = 16'h0000;
    rht   = 16'h0000;
    @(posedge clk); #1;
    rst    = 1'b0;
    m_peak = 0;
    m_n    = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (led !== 8'h00 || peak !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_init led=%h peak=%0d expected 00/0", led, peak);
    end
    rst = 1'b0;
    send(16'h7FFF, 16'h0000);
    for (int i = 0; i < 10; i++) send(16'h0000, 16'h0000);
    tests_run++;
    if (led !== exp_led(8)) begin
      tests_failed++;
      $display("FAIL reset_pre_hold led=%h expected %h", led, exp_led(8));
    end
    #5 rst = 1'b1;
    #1;
    tests_run++;
    if (led !== 8'h00 || peak !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_async led=%h peak=%0d expected 00/0", led, peak);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    m_peak = 0;
    m_n    = 0;
    send(16'h4000, 16'h0000);
    tests_run++;
    if (led !== exp_led(8) || peak !== 4'd8) begin
      tests_failed++;
      $display("FAIL reset_first_sample led=%h peak=%0d expected %h/8", led, peak, exp_led(8));
    end
  endtask

  task automatic test_level_encode();
    logic [15:0] tl[8] = '{16'h8000, 16'hFF38, 16'h0064, 16'h007F,
                           16'h0080, 16'h3FFF, 16'h0000, 16'h0FFF};
    logic [15:0] tr[8] = '{16'h0000, 16'h0000, 16'h012C, 16'h0000,
                           16'h0000, 16'h0000, 16'hC000, 16'hF000};
    int          tv[8] = '{8, 1, 2, 0, 1, 7, 8, 6};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(tl[i], tr[i]);
      tests_run++;
      if (led !== exp_led(tv[i]) || peak !== 4'(tv[i])) begin
        tests_failed++;
        $display("FAIL level_enc[%0d] led=%h peak=%0d expected %h/%0d",
                 i, led, peak, exp_led(tv[i]), tv[i]);
      end
    end
  endtask

  task automatic test_edge_latency();
    do_reset();
    lft   = 16'h0000;
    rht   = 16'h1000;
    valid = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (led !== 8'h00) begin
      tests_failed++;
      $display("FAIL latency_early led=%h expected 00", led);
    end
    @(posedge clk); #1;
    tests_run++;
    if (led !== exp_led(6) || peak !== 4'd6) begin
      tests_failed++;
      $display("FAIL latency_n2 led=%h peak=%0d expected %h/6", led, peak, exp_led(6));
    end
    repeat (3) @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (led !== exp_led(6)) begin
      tests_failed++;
      $display("FAIL held_valid led=%h expected %h", led, exp_led(6));
    end
  endtask

  task automatic test_hold_decay();
    int exp_lv;
    do_reset();
    send(16'h7FFF, 16'h0000);
    for (int i = 1; i <= H + 8 * D; i++) begin
      send(16'h0000, 16'h0000);
      if (i == H - 1 || i == H || i == H + D - 1 || i == H + D ||
          i == H + 8 * D - 1 || i == H + 8 * D) begin
        exp_lv = (i < H + D) ? 8 : (i == H + D) ? 7 : (i == H + 8 * D) ? 0 : 1;
        tests_run++;
        if (led !== exp_led(exp_lv) || peak !== 4'(exp_lv)) begin
          tests_failed++;
          $display("FAIL hold_decay@%0d led=%h peak=%0d expected %h/%0d",
                   i, led, peak, exp_led(exp_lv), exp_lv);
        end
      end
    end
    send(16'h0080, 16'h0000);
    tests_run++;
    if (led !== exp_led(1) || peak !== 4'd1) begin
      tests_failed++;
      $display("FAIL after_decay_track led=%h peak=%0d expected %h/1", led, peak, exp_led(1));
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(16'h7FFF, 16'h0000);
    for (int i = 0; i < H + 3 * D; i++) send(16'h0000, 16'h0000);
    tests_run++;
    if (peak !== 4'd5) begin
      tests_failed++;
      $display("FAIL decay_to_5 peak=%0d expected 5", peak);
    end
    send(16'h2000, 16'h0000);
    tests_run++;
    if (led !== exp_led(7) || peak !== 4'd7) begin
      tests_failed++;
      $display("FAIL retrigger led=%h peak=%0d expected %h/7", led, peak, exp_led(7));
    end
    send(16'h0200, 16'h0000);
    tests_run++;
    if (peak !== 4'd7) begin
      tests_failed++;
      $display("FAIL lower_in_hold peak=%0d expected 7", peak);
    end
    for (int i = 0; i < H - 1 + D - 1; i++) send(16'h0000, 16'h0000);
    tests_run++;
    if (peak !== 4'd7) begin
      tests_failed++;
      $display("FAIL rehold_end peak=%0d expected 7", peak);
    end
    send(16'h0000, 16'h0000);
    tests_run++;
    if (led !== exp_led(6) || peak !== 4'd6) begin
      tests_failed++;
      $display("FAIL rehold_decay led=%h peak=%0d expected %h/6", led, peak, exp_led(6));
    end
  endtask

  task automatic test_amp_on();
    do_reset();
    send(16'h7FFF, 16'h0000);
    for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000);
    amp_on = 1'b0;
    @(posedge clk); #1;
    m_peak = 0;
    m_n    = 0;
    tests_run++;
    if (led !== 8'h00 || peak !== 4'd0) begin
      tests_failed++;
      $display("FAIL amp_off led=%h peak=%0d expected 00/0", led, peak);
    end
    send(16'h7FFF, 16'h7FFF);
    send(16'h4000, 16'h0000);
    tests_run++;
    if (led !== 8'h00 || peak !== 4'd0) begin
      tests_failed++;
      $display("FAIL amp_off_ignore led=%h peak=%0d expected 00/0", led, peak);
    end
    amp_on = 1'b1;
    @(posedge clk); #1;
    send(16'h1000, 16'h0000);
    tests_run++;
    if (led !== exp_led(6) || peak !== 4'd6) begin
      tests_failed++;
      $display("FAIL amp_back led=%h peak=%0d expected %h/6", led, peak, exp_led(6));
    end
    // sample already in stage 1 when amp_on drops must not appear
    lft   = 16'h7FFF;
    valid = 1'b1;
    @(posedge clk); #1;
    amp_on = 1'b0;
    valid  = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (led !== 8'h00 || peak !== 4'd0) begin
      tests_failed++;
      $display("FAIL amp_off_inflight led=%h peak=%0d expected 00/0", led, peak);
    end
    amp_on = 1'b1;
    @(posedge clk); #1;
    m_peak = 0;
    m_n    = 0;
  endtask

  task automatic test_random();
    logic [15:0] l, r;
    int nb, ns;
    do_reset();
    for (int b = 0; b < 12; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        amp_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 amp_on = 1'b1;
        m_peak = 0;
        m_n    = 0;
        @(posedge clk); #1;
      end
      nb = $urandom_range(1, 30);
      ns = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2600) : $urandom_range(0, 300);
      for (int i = 0; i < nb + ns; i++) begin
        if (i < nb) begin
          l = 16'($urandom_range(0, 32767) >> $urandom_range(0, 14));
          r = 16'($urandom_range(0, 32767) >> $urandom_range(0, 14));
          if ($urandom_range(0, 1) == 1) l = 16'h0000 - l;
          if ($urandom_range(0, 1) == 1) r = 16'h0000 - r;
          if ($urandom_range(0, 15) == 0) l = 16'h8000;
        end else begin
          l = 16'h0000;
          r = 16'h0000;
        end
        send(l, r);
        tests_run++;
        if (led !== exp_led(m_disp()) || peak !== 4'(m_disp())) begin
          tests_failed++;
          $display("FAIL random b%0d s%0d L=%h R=%h led=%h peak=%0d expected %h/%0d",
                   b, i, l, r, led, peak, exp_led(m_disp()), m_disp());
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    amp_on = 1'b1;
    valid  = 1'b0;
    lft    = 16'h0000;
    rht    = 16'h0000;
    test_reset();
    test_level_encode();
    test_edge_latency();
    test_hold_decay();
    test_retrigger();
    test_amp_on();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vu_meter.md
# vu_meter

Stereo peak-level meter that drives the 8 board LEDs from the equalizer output samples. It sits downstream of the equalizer engine, beside the CODEC interface, and consumes the same `lft_out`/`rht_out`/`valid` the CODEC consumes. It converts each stereo sample to a 0–8 log-scale level and displays it with a peak-hold and stepwise decay. It replaces the static volume-based LED decode at the top level.

## Interface
- HOLD_SAMPLES, 2048: samples the displayed peak is held before decay starts (≥1)
- DECAY_SAMPLES, 256: samples per one-LED decay step (≥1)
- clk  input  1  50 MHz system clock
- rst  input  1  asynchronous, active-high reset
- valid  input  1  CODEC sample strobe; one new stereo pair per rising edge
- lft_out  input  16  signed left sample
- rht_out  input  16  signed right sample
- amp_on  input  1  amplifier enabled; meter is blanked while low
- LED  output  8  active-high LED drive, registered
- peak_lvl  output  4  currently displayed level 0..8, registered

## Operation
- Sample event: `valid` high this cycle and low the previous cycle (internal edge detect). A `valid` held high for several cycles counts once.
- Magnitude: |x| per channel, saturating, so −32768 gives 32767. mag = max(|L|, |R|), 15 bits unsigned.
- Level: count of k in 1..8 with mag ≥ 2^(6+k).
  - Thresholds are 128, 256, …, 16384, about 6 dB per LED.
  - mag < 128 gives level 0.
- FSM states: IDLE, TRACK, HOLD, DECAY. All transitions below are evaluated only on sample events, except the amp_on rule.
  - IDLE:
    - Entered on reset or whenever amp_on=0, regardless of state.
    - disp=0, counters cleared, sample events ignored.
    - Goes to TRACK when amp_on=1.
  - TRACK, HOLD, DECAY: if new level ≥ disp and new level > 0:
    - disp ← new level, hold_cnt ← HOLD_SAMPLES, state ← HOLD.
    - An equal level re-arms the hold.
  - Otherwise, per state:
    - TRACK: stays in TRACK.
    - HOLD: hold_cnt decrements. On reaching 0: state ← DECAY, dec_cnt ← DECAY_SAMPLES.
    - DECAY: dec_cnt decrements. On reaching 0: disp ← disp−1 and dec_cnt reloads. If disp becomes 0, state ← TRACK.
- LED (macro undefined): thermometer, LED[i]=1 for i < disp.
- peak_lvl = disp in every mode.
- Counter width: $clog2(max(HOLD_SAMPLES, DECAY_SAMPLES)+1). Counters never underflow.

## Timing
- Reset: LED=8'h00, peak_lvl=0, state IDLE, all counters and the edge-detect flop at 0.
- Reset asserted mid-operation clears everything asynchronously. The first sample event is accepted in the cycle after release.
- Latency: a sample event in cycle N updates LED and peak_lvl visibly from cycle N+2.
  - Stage 1 registers mag.
  - Stage 2 encodes level and updates the FSM and outputs.
- amp_on falling: LED=0 and peak_lvl=0 from the cycle after amp_on is sampled low, including any sample already in stage 1.
- Minimum sample spacing is 2 clocks; the CODEC spacing is ~1024.
- After a full-scale peak and silence, full decay to 0 takes HOLD_SAMPLES + 8·DECAY_SAMPLES sample events.

## Configuration
- VU_PEAK_DOT_EN defined: dot mode. LED is one-hot at bit disp−1, and 8'h00 when disp=0.
- VU_PEAK_DOT_EN undefined: thermometer bar as above.
- FSM, latency and peak_lvl are identical in both modes.

## Structure
- Package vu_pkg holds:
  - state enum {IDLE, TRACK, HOLD, DECAY}
  - NUM_LEDS=8
  - LVL_W=4
  - threshold base exponent 7
- Sub-module vu_level_enc: combinational 15-bit magnitude → 4-bit level. It is instantiated once in stage 2.
- Top holds the edge detect, abs/max stage, FSM, counters and output registers.

## Test plan
- Reset: assert rst mid-hold with LED=8'hFF → LED=8'h00, peak_lvl=0 immediately. Next sample L=16'h4000 → LED=8'hFF.
- Level encode, one pulse each with amp_on=1 and a reset between pulses:
  - L=16'h8000 → peak_lvl=8
  - L=−200, R=0 → LED=8'h01
  - L=100, R=300 → LED=8'h03
  - L=127 → LED=8'h00
- Latency and edge: `valid` high 5 cycles with R=16'h1000 → one event; LED=8'h3F exactly 2 cycles after the rise.
- Hold/decay (defaults): one full-scale sample, then zeros → LED=8'hFF for 2048 samples, 8'h7F after 256 more, 8'h00 after 4096 total; state TRACK.
- Retrigger during DECAY at disp=5: sample with level 7 → LED=8'h7F and the hold restarts for 2048 samples. A level-3 sample during HOLD leaves disp unchanged.
- amp_on dropped during HOLD → LED=0 next cycle, later samples ignored. amp_on=1 again → TRACK. With VU_PEAK_DOT_EN and level 6 → LED=8'h20.
